// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the byte-enable bus width.
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Handshake: mem_cs/mem_wr/mem_addr/mem_wdata/mem_be are held stable by the master
// until the slave returns mem_ack=1 for one cycle; mem_rdata is valid only with mem_ack.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic            mem_cs;
    logic            mem_wr;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [BE_W-1:0] mem_be;
    logic [31:0]     mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_cs, mem_wr, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_cs, mem_wr, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane handling: store replication, byte enables and load extraction.
// Offset 0 is bits 31:24, offset 3 is bits 7:0.
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            sign_ext,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata_raw,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_rep,
    output logic [31:0]     rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata_raw[31:24];
            2'd1:    byte_lane = rdata_raw[23:16];
            2'd2:    byte_lane = rdata_raw[15:8];
            default: byte_lane = rdata_raw[7:0];
        endcase
        half_lane = offset[1] ? rdata_raw[15:0] : rdata_raw[31:16];
    end

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b1000 >> offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                be        = offset[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata_raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: captures a request, runs one memory access with ack/timeout,
// and returns an aligned, extended load result. All outputs decode from flops.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         rdata,
    mem_access_unit_if.master   mem,
    output state_t              dbg_state
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q, sign_q, err_q, err_d;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        capture, load_rdata, misaligned, cs;
    logic [3:0]  be_w;
    logic [31:0] wdata_rep, rdata_ext;

    assign misaligned = (size == SZ_ILL) ||
                        (size == SZ_HALF && addr[0]) ||
                        (size == SZ_WORD && addr[1:0] != 2'b00);

    lane_align u_lane_align (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .rdata_raw (mem.mem_rdata),
        .be        (be_w),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    err_d   = misaligned;
                    cnt_d   = '0;
                    state_d = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the final count still completes without error.
                if (mem.mem_ack) begin
                    load_rdata = ~we_q;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= we;
                sign_q  <= sign_ext;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (load_rdata) begin
                rdata_q <= rdata_ext;
            end
        end
    end

    assign cs            = (state_q == ACCESS);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = done & err_q;
    assign rdata         = rdata_q;
    assign dbg_state     = state_q;
    assign mem.mem_cs    = cs;
    assign mem.mem_wr    = cs & we_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_be    = cs ? be_w : '0;
    assign mem.mem_wdata = cs ? wdata_rep : '0;

endmodule
